// File: rtl/rat_flag_unit.sv
// rat_flag_unit: RAT CPU C/Z flag register with interrupt shadow-flag LIFO
// Ports:
//   CLK, RST_N              rising-edge clock, asynchronous active-low reset
//   ALU_C, ALU_Z            combinational carry/zero results from the ALU
//   FLG_C_LD, FLG_Z_LD      load C/Z from the ALU
//   FLG_C_SET, FLG_C_CLR    force C to 1 (SEC) / 0 (CLC)
//   FLG_SHAD_PUSH/POP       interrupt entry saves {C,Z}; RETI restores them
//   C_FLAG, Z_FLAG, CIN     architectural flags; CIN is C_FLAG fed back to the ALU
//   SHAD_CNT                stack occupancy
//   SHAD_OVF, SHAD_UNF      sticky push-while-full / pop-while-empty
// Optional macro RAT_FLG_PUSH_CLR_EN: a successful push also clears C and Z.
module rat_flag_unit #(
  parameter int SHAD_DEPTH = 2,
  parameter int CW = $clog2(SHAD_DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ALU_C,
  input  logic          ALU_Z,
  input  logic          FLG_C_LD,
  input  logic          FLG_Z_LD,
  input  logic          FLG_C_SET,
  input  logic          FLG_C_CLR,
  input  logic          FLG_SHAD_PUSH,
  input  logic          FLG_SHAD_POP,
  output logic          C_FLAG,
  output logic          Z_FLAG,
  output logic          CIN,
  output logic [CW-1:0] SHAD_CNT,
  output logic          SHAD_OVF,
  output logic          SHAD_UNF
);
  logic [2*SHAD_DEPTH-1:0] stk;
  logic pop_ok, push_ok, push_clr, c_nxt, z_nxt;
  logic [1:0] top;
  int rd_i, wr_i;
  assign CIN = C_FLAG;
  // A push alongside a valid pop always succeeds: it rewrites the slot the pop frees.
  always_comb begin
    pop_ok = FLG_SHAD_POP && SHAD_CNT != '0;
    push_ok = FLG_SHAD_PUSH && (SHAD_CNT != CW'(SHAD_DEPTH) || pop_ok);
    rd_i = pop_ok ? int'(SHAD_CNT) - 1 : 0;
    wr_i = pop_ok ? rd_i : int'(SHAD_CNT);
    top = stk[2*rd_i +: 2];
`ifdef RAT_FLG_PUSH_CLR_EN
    push_clr = push_ok && !pop_ok;
`else
    push_clr = 1'b0;
`endif
    c_nxt = pop_ok ? top[1] : push_clr ? 1'b0 : FLG_C_SET ? 1'b1 : FLG_C_CLR ? 1'b0 : FLG_C_LD ? ALU_C : C_FLAG;
    z_nxt = pop_ok ? top[0] : push_clr ? 1'b0 : FLG_Z_LD ? ALU_Z : Z_FLAG;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      C_FLAG <= 1'b0;
      Z_FLAG <= 1'b0;
      stk <= '0;
      SHAD_CNT <= '0;
      SHAD_OVF <= 1'b0;
      SHAD_UNF <= 1'b0;
    end else begin
      C_FLAG <= c_nxt;
      Z_FLAG <= z_nxt;
      if (push_ok) stk[2*wr_i +: 2] <= {C_FLAG, Z_FLAG};
      if (push_ok != pop_ok) SHAD_CNT <= push_ok ? SHAD_CNT + CW'(1) : SHAD_CNT - CW'(1);
      if (FLG_SHAD_PUSH && !push_ok) SHAD_OVF <= 1'b1;
      if (FLG_SHAD_POP && !FLG_SHAD_PUSH && !pop_ok) SHAD_UNF <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rat_flag_unit.sv
// tb_rat_flag_unit: vector table, corner sequences and random run against a queue model
module tb_rat_flag_unit;
  localparam int D = 2;
  localparam int CW = $clog2(D + 1);
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_c = 0, alu_z = 0, c_ld = 0, z_ld = 0, c_set = 0, c_clr = 0, push = 0, pop = 0;
  logic c_flag, z_flag, cin, ovf, unf;
  logic [CW-1:0] cnt;
  int errors = 0, checks = 0;
  typedef struct {
    logic push, pop, ldc, ldz, set, clr, ac, az;
    logic c, z;
    logic [CW-1:0] cnt;
    logic ovf, unf;
  } vec_t;
  vec_t tbl[26];
  logic mc, mz, movf, munf;
  logic [1:0] mq[$];

  rat_flag_unit #(.SHAD_DEPTH(D)) dut (
    .CLK(clk), .RST_N(rst_n), .ALU_C(alu_c), .ALU_Z(alu_z),
    .FLG_C_LD(c_ld), .FLG_Z_LD(z_ld), .FLG_C_SET(c_set), .FLG_C_CLR(c_clr),
    .FLG_SHAD_PUSH(push), .FLG_SHAD_POP(pop),
    .C_FLAG(c_flag), .Z_FLAG(z_flag), .CIN(cin), .SHAD_CNT(cnt),
    .SHAD_OVF(ovf), .SHAD_UNF(unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end, errors=%0d", errors);
    $fatal(1);
  end

  function automatic vec_t mk(input logic pu, po, lc, lz, st, cl, ac, az, ec, ez, input logic [CW-1:0] en, input logic eo, eu);
    vec_t v;
    v.push = pu; v.pop = po; v.ldc = lc; v.ldz = lz; v.set = st; v.clr = cl; v.ac = ac; v.az = az;
    v.c = ec; v.z = ez; v.cnt = en; v.ovf = eo; v.unf = eu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    mc = 0; mz = 0; movf = 0; munf = 0;
    mq.delete();
  endtask

  task automatic model_step(input logic pu, po, lc, lz, st, cl, ac, az);
    logic [1:0] old;
    bit pushed;
    int n;
    n = mq.size();
    pushed = 0;
    if (po && pu && n > 0) begin
      old = mq[n-1];
      mq[n-1] = {mc, mz};
      {mc, mz} = old;
    end else if (po && n > 0) begin
      old = mq.pop_back();
      {mc, mz} = old;
    end else begin
      if (pu) begin
        if (n < D) begin
          mq.push_back({mc, mz});
          pushed = 1;
        end else movf = 1;
      end
      if (po && !pu) munf = 1;
      mc = st ? 1'b1 : cl ? 1'b0 : lc ? ac : mc;
      mz = lz ? az : mz;
`ifdef RAT_FLG_PUSH_CLR_EN
      if (pushed) begin mc = 0; mz = 0; end
`endif
    end
  endtask

  task automatic drive(input logic pu, po, lc, lz, st, cl, ac, az);
    push = pu; pop = po; c_ld = lc; z_ld = lz; c_set = st; c_clr = cl; alu_c = ac; alu_z = az;
    @(posedge clk);
    #1;
    model_step(pu, po, lc, lz, st, cl, ac, az);
  endtask

  task automatic check_exp(input string tag, input logic ec, ez, input logic [CW-1:0] en, input logic eo, eu);
    chk({tag, ".c"}, {7'd0, c_flag}, {7'd0, ec});
    chk({tag, ".z"}, {7'd0, z_flag}, {7'd0, ez});
    chk({tag, ".cin"}, {7'd0, cin}, {7'd0, ec});
    chk({tag, ".cnt"}, 8'(cnt), 8'(en));
    chk({tag, ".ovf"}, {7'd0, ovf}, {7'd0, eo});
    chk({tag, ".unf"}, {7'd0, unf}, {7'd0, eu});
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 0;
    #1 check_exp(tag, 0, 0, '0, 0, 0);
    model_reset();
    #2 rst_n = 1;
  endtask

  initial begin
    tbl[0]  = mk(0,0,1,1,0,0,1,0, 1,0,0,0,0);
    tbl[1]  = mk(0,0,0,0,1,1,0,0, 1,0,0,0,0);
    tbl[2]  = mk(0,0,0,1,0,1,0,1, 0,1,0,0,0);
    tbl[3]  = mk(0,0,0,1,1,0,0,0, 1,0,0,0,0);
    tbl[4]  = mk(1,0,0,0,0,0,0,0, 1,0,1,0,0);
    tbl[5]  = mk(0,0,0,1,0,1,0,1, 0,1,1,0,0);
    tbl[6]  = mk(1,0,0,0,0,0,0,0, 0,1,2,0,0);
    tbl[7]  = mk(0,1,0,0,0,0,0,0, 0,1,1,0,0);
    tbl[8]  = mk(0,1,0,0,0,0,0,0, 1,0,0,0,0);
    tbl[9]  = mk(1,0,0,0,0,0,0,0, 1,0,1,0,0);
    tbl[10] = mk(0,0,0,1,0,1,0,1, 0,1,1,0,0);
    tbl[11] = mk(1,0,0,0,0,0,0,0, 0,1,2,0,0);
    tbl[12] = mk(0,0,0,1,1,0,0,0, 1,0,2,0,0);
    tbl[13] = mk(1,0,0,1,0,0,0,1, 1,1,2,1,0);
    tbl[14] = mk(0,1,0,0,0,0,0,0, 0,1,1,1,0);
    tbl[15] = mk(0,1,0,0,0,0,0,0, 1,0,0,1,0);
    tbl[16] = mk(0,1,0,0,1,0,0,0, 1,0,0,1,1);
    tbl[17] = mk(0,1,0,0,0,0,0,0, 1,0,0,1,1);
    tbl[18] = mk(0,0,0,1,0,1,0,0, 0,0,0,1,1);
    tbl[19] = mk(1,0,0,0,0,0,0,0, 0,0,1,1,1);
    tbl[20] = mk(0,0,0,1,1,0,0,1, 1,1,1,1,1);
    tbl[21] = mk(1,1,0,0,0,0,0,0, 0,0,1,1,1);
    tbl[22] = mk(0,1,0,0,0,0,0,0, 1,1,0,1,1);
    tbl[23] = mk(1,0,0,0,0,0,0,0, 1,1,1,1,1);
    tbl[24] = mk(0,0,0,1,0,1,0,0, 0,0,1,1,1);
    tbl[25] = mk(0,1,1,1,0,1,0,0, 1,1,0,1,1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_exp("reset", 0, 0, '0, 0, 0);
    #3 rst_n = 1;
    for (int i = 0; i < 26; i++) begin
      drive(tbl[i].push, tbl[i].pop, tbl[i].ldc, tbl[i].ldz, tbl[i].set, tbl[i].clr, tbl[i].ac, tbl[i].az);
      check_exp($sformatf("vec%0d", i), tbl[i].c, tbl[i].z, tbl[i].cnt, tbl[i].ovf, tbl[i].unf);
    end
    drive(1,0,0,0,0,0,0,0);
    check_exp("pre_rst", 1, 1, 1, 1, 1);
    async_reset("async_rst");
    drive(1,1,0,0,0,0,0,0);
    check_exp("pushpop_empty", 0, 0, 1, 0, 0);
    drive(0,1,0,0,0,0,0,0);
    drive(0,0,0,0,1,0,0,0);
    check_exp("set_c", 1, 0, 0, 0, 0);
    drive(1,0,0,1,0,0,0,1);
`ifdef RAT_FLG_PUSH_CLR_EN
    check_exp("push_ldz", 0, 0, 1, 0, 0);
`else
    check_exp("push_ldz", 1, 1, 1, 0, 0);
`endif
    drive(0,1,0,0,0,0,0,0);
    check_exp("push_ldz_pop", 1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 350) async_reset("rand_rst");
      drive($urandom_range(3) == 0, $urandom_range(3) == 0, 1'($urandom), 1'($urandom),
            $urandom_range(4) == 0, $urandom_range(4) == 0, 1'($urandom), 1'($urandom));
      check_exp("rand", mc, mz, CW'(mq.size()), movf, munf);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rat_flag_unit.md
Name: rat_flag_unit

Overview:
- Flag register and interrupt shadow-flag stack for the RAT CPU.
- Consumes the ALU's combinational C and Z outputs under control-unit load strobes, and holds the architectural C/Z flags.
- Feeds C back to the ALU as its carry-in.
- On interrupt entry it saves {C,Z} to a small LIFO; on RETI it restores them.

Parameters:
- SHAD_DEPTH, 2, number of {C,Z} entries in the shadow stack (nested-interrupt depth); legal range 1..8.
- CW, $clog2(SHAD_DEPTH+1), width of the stack occupancy count (derived; do not override).

Ports:
- CLK  in  1  system clock, rising-edge.
- RST_N  in  1  asynchronous active-low reset.
- ALU_C  in  1  carry result from ALU.
- ALU_Z  in  1  zero result from ALU.
- FLG_C_LD  in  1  load C from ALU_C.
- FLG_Z_LD  in  1  load Z from ALU_Z.
- FLG_C_SET  in  1  force C=1 (SEC).
- FLG_C_CLR  in  1  force C=0 (CLC).
- FLG_SHAD_PUSH  in  1  interrupt acknowledge: push current {C,Z}.
- FLG_SHAD_POP  in  1  RETI: pop top entry into {C,Z}.
- C_FLAG  out  1  architectural carry flag.
- Z_FLAG  out  1  architectural zero flag.
- CIN  out  1  carry-in to ALU; combinational alias of C_FLAG.
- SHAD_CNT  out  CW  entries currently held in the stack.
- SHAD_OVF  out  1  sticky: push attempted while full.
- SHAD_UNF  out  1  sticky: pop attempted while empty.

Behaviour:
- Reset: RST_N low asynchronously clears C_FLAG, Z_FLAG, SHAD_CNT, SHAD_OVF, SHAD_UNF and all stack entries to 0. Release is synchronous to the next CLK edge.
- All state updates occur on the rising CLK edge. Outputs are registered, except CIN.
- C next-value priority, highest first:
  - valid pop: takes the popped C.
  - FLG_C_SET: 1.
  - FLG_C_CLR: 0.
  - FLG_C_LD: ALU_C.
  - otherwise: hold.
- Z next-value priority: valid pop (popped Z), then FLG_Z_LD (ALU_Z), else hold.
- Push, not full: entry[SHAD_CNT] is written with the pre-edge {C,Z} and SHAD_CNT increments.
  - Loads, SET or CLR in the same cycle still update the live flags.
  - The pushed value is the old one.
- Push while full (SHAD_CNT==SHAD_DEPTH): the stack is unchanged, SHAD_OVF is set, and the live flags update normally.
- Pop, not empty: {C,Z} is loaded from entry[SHAD_CNT-1] and SHAD_CNT decrements. Pop overrides all loads, SET and CLR that cycle.
- Pop while empty: no flag change from the pop. Other strobes still apply and SHAD_UNF is set.
- Push and pop in the same cycle with SHAD_CNT>0:
  - the live flags take the old top;
  - the top entry is overwritten with the old live flags;
  - SHAD_CNT is unchanged.
- Push and pop in the same cycle with SHAD_CNT==0: treated as a push only. SHAD_UNF is not set.
- SHAD_OVF and SHAD_UNF clear only on reset.
- Latency: a strobe at edge N is visible on C_FLAG, Z_FLAG and CIN after edge N. Zero wait states.

Optional Feature:
- Macro: RAT_FLG_PUSH_CLR_EN.
- Defined: a successful push also clears C_FLAG and Z_FLAG at the same edge, so the ISR starts with clean flags.
  - This clear takes priority over same-cycle LD, SET and CLR.
  - The push-and-pop-together case is unaffected; pop wins.
- Undefined: the live flags retain or update per normal priority on push.

Test Plan:
- Reset mid-operation: SHAD_CNT=1, C=1, Z=1, assert RST_N=0 between edges -> all outputs 0 immediately, without waiting for CLK.
- ALU_C=1, ALU_Z=0, FLG_C_LD=1, FLG_Z_LD=1 -> C_FLAG=1, Z_FLAG=0 and CIN=1 after one edge. Then FLG_C_SET=1 and FLG_C_CLR=1 together -> C_FLAG=1.
- C=1, Z=0, push; then C=0, Z=1, push (SHAD_CNT=2); then pop -> {C,Z}={0,1}; pop again -> {1,0}, SHAD_CNT=0.
- SHAD_DEPTH=2, three pushes -> SHAD_CNT=2 and SHAD_OVF=1. Two pops then return the first two saved values. A third pop sets SHAD_UNF=1 with flags unchanged.
- C=1, Z=1, SHAD_CNT=1 holding {0,0}: push and pop in the same cycle -> C=0, Z=0, SHAD_CNT=1, top entry={1,1}.
- C=1, Z=0, SHAD_CNT=0: push and FLG_Z_LD (ALU_Z=1) in the same cycle.
  - Without the macro -> stack holds {1,0}, Z_FLAG=1.
  - With RAT_FLG_PUSH_CLR_EN -> stack holds {1,0}, C=0, Z=0.
